// File: rtl/x_dl_reporter.sv
// x_dl_reporter
// Captures a delay-line thermometer sample on a strobe, counts its set taps,
// and streams a framed byte packet toward a UART transmitter.
//
// Packet: header, sample bytes (MS byte first), popcount, XOR checksum of all
// preceding bytes. Length is p_width/8 + 3.
//
// Ports:
//   i_clk       clock
//   i_rst_n     asynchronous active-low reset
//   i_capture   single-cycle capture strobe
//   i_dl        delay-line sample (p_width bits)
//   o_valid     packet byte available
//   o_data      packet byte
//   i_accept    downstream takes o_data when o_valid && i_accept
//   o_busy      packet in progress, captures refused
//   o_drop_cnt  saturating count of refused captures
//
// state  | meaning
// S_IDLE | waiting for a capture, o_valid=0, o_busy=0
// S_SEND | presenting packet byte r_idx, o_valid=1, o_busy=1
module x_dl_reporter #(
    parameter int          p_width  = 32,
    parameter logic [7:0]  p_header = 8'hA5
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_capture,
    input  logic [p_width-1:0] i_dl,
    output logic               o_valid,
    output logic [7:0]         o_data,
    input  logic               i_accept,
    output logic               o_busy,
    output logic [7:0]         o_drop_cnt
);

    localparam int         c_nbytes = p_width / 8;
    localparam logic [7:0] c_pop_idx = 8'(c_nbytes + 1);
    localparam logic [7:0] c_last    = 8'(c_nbytes + 2);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_SEND = 1'b1;

    logic [0:0]         r_state;
    logic [p_width-1:0] r_sample;
    logic [7:0]         r_pop;
    logic [7:0]         r_idx;
    logic [7:0]         r_csum;
    logic [7:0]         r_data;
    logic [7:0]         r_drop;

    logic [7:0]         w_pop;
    logic [7:0]         w_idx_next;
    logic [7:0]         w_csum_next;
    logic [7:0]         w_next_byte;

    always_comb begin
        w_pop = 8'd0;
        for (int i = 0; i < p_width; i++) begin
            w_pop = w_pop + 8'(i_dl[i]);
        end
    end

    // Byte that follows the one currently on o_data. The checksum byte folds in
    // the byte being accepted right now, so it uses the updated running XOR.
    always_comb begin
        w_idx_next  = r_idx + 8'd1;
        w_csum_next = r_csum ^ r_data;
        w_next_byte = 8'h00;
        if (w_idx_next == c_pop_idx) begin
            w_next_byte = r_pop;
        end else if (w_idx_next == c_last) begin
            w_next_byte = w_csum_next;
        end else begin
            for (int b = 0; b < c_nbytes; b++) begin
                if (w_idx_next == 8'(c_nbytes - b)) begin
                    w_next_byte = r_sample[b*8 +: 8];
                end
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state  <= S_IDLE;
            r_sample <= '0;
            r_pop    <= 8'd0;
            r_idx    <= 8'd0;
            r_csum   <= 8'd0;
            r_data   <= 8'h00;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_capture) begin
                        r_sample <= i_dl;
                        r_pop    <= w_pop;
                        r_idx    <= 8'd0;
                        r_csum   <= 8'd0;
                        r_data   <= p_header;
                        r_state  <= S_SEND;
                    end
                end
                S_SEND: begin
                    if (i_accept) begin
                        r_csum <= w_csum_next;
                        if (r_idx == c_last) begin
                            r_state <= S_IDLE;
                            r_data  <= 8'h00;
                        end else begin
                            r_idx  <= w_idx_next;
                            r_data <= w_next_byte;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Refused captures include the cycle the checksum byte is accepted.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_drop <= 8'd0;
        end else if ((r_state == S_SEND) && i_capture && (r_drop != 8'hFF)) begin
            r_drop <= r_drop + 8'd1;
        end
    end

    assign o_valid    = (r_state == S_SEND);
    assign o_busy     = (r_state == S_SEND);
    assign o_data     = r_data;
    assign o_drop_cnt = r_drop;

endmodule
